// File: rtl/ncl_thmn_array.sv
// rtl/ncl_thmn_array.sv - clocked array of NCL THmn threshold gates with completion and wavefront count
module ncl_thmn_array #(
   parameter int N       = 2,
   parameter int M       = 1,
   parameter int CH      = 4,
   parameter int RST_VAL = 0,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CH*N-1:0]     a,
   output logic [CH-1:0]       y,
   output logic                done,
   output logic [CNT_W-1:0]    wave_cnt
);

   localparam int   KW = $clog2(N + 1);
   localparam logic RV = (RST_VAL != 0);

   // Reject gate shapes that have no meaningful threshold behaviour.
   if (N < 2 || N > 8 || M < 1 || M > N || CH < 1 || CH > 64 || CNT_W < 1 || CNT_W > 32)
   begin : g_param_check
      $fatal(1, "ncl_thmn_array: illegal parameters N=%0d M=%0d CH=%0d CNT_W=%0d", N, M, CH, CNT_W);
   end

   logic [KW-1:0] k [CH];
   logic [CH-1:0] y_nxt;
   logic          done_nxt;

   // Per-channel popcount and THmn set / clear / hold decision.
   always_comb begin
      y_nxt = y;
      for (int c = 0; c < CH; c++) begin
         k[c] = '0;
         for (int i = 0; i < N; i++) begin
            k[c] = k[c] + KW'(a[c*N + i]);
         end
         if (k[c] >= KW'(M)) begin
            y_nxt[c] = 1'b1;
         end else if (k[c] == '0) begin
            y_nxt[c] = 1'b0;
         end
      end
   end

   // Completion acts as a CH-input C-element on the registered gate outputs.
   always_comb begin
      done_nxt = done;
      if (&y) begin
         done_nxt = 1'b1;
      end else if (~|y) begin
         done_nxt = 1'b0;
      end
   end

   // State update; the counter advances on the same edge that raises done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y        <= {CH{RV}};
         done     <= RV;
         wave_cnt <= '0;
      end else if (en) begin
         y    <= y_nxt;
         done <= done_nxt;
         if (!done && done_nxt) begin
            wave_cnt <= wave_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ncl_thmn_array.sv
// tb/tb_ncl_thmn_array.sv - directed self-checking bench for ncl_thmn_array
module tb_ncl_thmn_array;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // u0: TH12 x4, 2-bit counter
   logic       rst0, en0;
   logic [7:0] a0;
   logic [3:0] y0;
   logic       done0;
   logic [1:0] cnt0;

   // u1: TH23 x1
   logic       rst1, en1;
   logic [2:0] a1;
   logic [0:0] y1;
   logic       done1;
   logic [7:0] cnt1;

   // u2: TH12 x2, D-type reset
   logic       rst2, en2;
   logic [3:0] a2;
   logic [1:0] y2;
   logic       done2;
   logic [7:0] cnt2;

   ncl_thmn_array #(.N(2), .M(1), .CH(4), .RST_VAL(0), .CNT_W(2)) u0 (
      .clk(clk), .rst(rst0), .en(en0), .a(a0), .y(y0), .done(done0), .wave_cnt(cnt0));

   ncl_thmn_array #(.N(3), .M(2), .CH(1), .RST_VAL(0), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst1), .en(en1), .a(a1), .y(y1), .done(done1), .wave_cnt(cnt1));

   ncl_thmn_array #(.N(2), .M(1), .CH(2), .RST_VAL(1), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst2), .en(en2), .a(a2), .y(y2), .done(done2), .wave_cnt(cnt2));

   int checks = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string tag, input logic [3:0] ey, input logic ed, input logic [1:0] ec);
      chk({tag, ".y"}, 32'(y0), 32'(ey));
      chk({tag, ".done"}, 32'(done0), 32'(ed));
      chk({tag, ".cnt"}, 32'(cnt0), 32'(ec));
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      en0 = 1'b1;  en1 = 1'b1;  en2 = 1'b1;
      a0 = '0; a1 = '0; a2 = '0;
      #3;
      chk0("reset_u0", 4'b0000, 1'b0, 2'd0);
      chk("reset_u1.y", 32'(y1), 32'd0);
      chk("reset_u2.y", 32'(y2), 32'b11);
      chk("reset_u2.done", 32'(done2), 32'd1);
      chk("reset_u2.cnt", 32'(cnt2), 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;

      // TH12 equivalence
      tick();
      chk0("th12_00", 4'b0000, 1'b0, 2'd0);
      a0 = {4{2'b01}}; tick();
      chk0("th12_01", 4'b1111, 1'b0, 2'd0);
      a0 = {4{2'b10}}; tick();
      chk0("th12_10", 4'b1111, 1'b1, 2'd1);
      a0 = {4{2'b11}}; tick();
      chk0("th12_11", 4'b1111, 1'b1, 2'd1);
      a0 = '0; tick();
      chk0("th12_back00", 4'b0000, 1'b1, 2'd1);
      tick();
      chk0("th12_null_done", 4'b0000, 1'b0, 2'd1);
      a0 = 8'b11_10_01_00; tick();
      chk0("th12_mixed", 4'b1110, 1'b0, 2'd1);
      tick();
      chk0("th12_mixed_hold", 4'b1110, 1'b0, 2'd1);
      a0 = '0; tick(); tick();
      chk0("th12_clear", 4'b0000, 1'b0, 2'd1);

      // Completion: raise one channel per clock
      a0 = 8'b00_00_00_01; tick();
      chk0("raise1", 4'b0001, 1'b0, 2'd1);
      a0 = 8'b00_00_01_01; tick();
      chk0("raise2", 4'b0011, 1'b0, 2'd1);
      a0 = 8'b00_01_01_01; tick();
      chk0("raise3", 4'b0111, 1'b0, 2'd1);
      a0 = 8'b01_01_01_01; tick();
      chk0("raise4", 4'b1111, 1'b0, 2'd1);
      tick();
      chk0("raise_done", 4'b1111, 1'b1, 2'd2);
      a0 = 8'b00_00_00_01; tick();
      chk0("lower3", 4'b0001, 1'b1, 2'd2);
      tick();
      chk0("lower3_hold", 4'b0001, 1'b1, 2'd2);
      a0 = '0; tick();
      chk0("lower4", 4'b0000, 1'b1, 2'd2);
      tick();
      chk0("lower4_done", 4'b0000, 1'b0, 2'd2);

      // Two more wavefronts: 3 then wrap to 0
      a0 = 8'hFF; tick(); tick();
      chk0("wave3", 4'b1111, 1'b1, 2'd3);
      a0 = '0; tick(); tick();
      a0 = 8'hFF; tick(); tick();
      chk0("wave_wrap", 4'b1111, 1'b1, 2'd0);
      a0 = '0; tick(); tick();
      chk0("wave_wrap_null", 4'b0000, 1'b0, 2'd0);

      // Enable hold
      en0 = 1'b0; a0 = 8'hFF;
      repeat (5) tick();
      chk0("en_hold", 4'b0000, 1'b0, 2'd0);
      en0 = 1'b1; tick();
      chk0("en_resume_y", 4'b1111, 1'b0, 2'd0);
      tick();
      chk0("en_resume_done", 4'b1111, 1'b1, 2'd1);

      // Hysteresis TH23
      a1 = 3'b001; tick();
      chk("hyst_001_low", 32'(y1), 32'd0);
      a1 = 3'b011; tick();
      chk("hyst_011_set", 32'(y1), 32'd1);
      a1 = 3'b001; tick();
      chk("hyst_001_hold", 32'(y1), 32'd1);
      a1 = 3'b000; tick();
      chk("hyst_000_clr", 32'(y1), 32'd0);
      a1 = 3'b100; tick();
      chk("hyst_100_low", 32'(y1), 32'd0);
      a1 = 3'b111; tick();
      chk("hyst_111_set", 32'(y1), 32'd1);

      // D-type reset, async pulse mid-wavefront
      chk("u2_held_y", 32'(y2), 32'b11);
      a2 = 4'b00_01; rst2 = 1'b0; tick();
      chk("u2_y01", 32'(y2), 32'b01);
      chk("u2_y01_done", 32'(done2), 32'd1);
      chk("u2_y01_cnt", 32'(cnt2), 32'd0);
      rst2 = 1'b1; #1;
      chk("async_rst_y", 32'(y2), 32'b11);
      chk("async_rst_done", 32'(done2), 32'd1);
      chk("async_rst_cnt", 32'(cnt2), 32'd0);
      #1 rst2 = 1'b0;
      a2 = '0; tick();
      chk("post_rst_y", 32'(y2), 32'b00);
      chk("post_rst_done1", 32'(done2), 32'd1);
      tick();
      chk("post_rst_done0", 32'(done2), 32'd0);
      chk("post_rst_cnt0", 32'(cnt2), 32'd0);
      a2 = 4'b01_01; tick();
      chk("u2_data_y", 32'(y2), 32'b11);
      chk("u2_data_done0", 32'(done2), 32'd0);
      tick();
      chk("u2_data_done1", 32'(done2), 32'd1);
      chk("u2_data_cnt1", 32'(cnt2), 32'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
